// File: rtl/bias_lshift_sat_pkg.sv
// bias_lshift_sat_pkg: shift range and accumulator width shared by the bias shift paths
package bias_lshift_sat_pkg;
  localparam int SHIFT_W = 5;
  localparam int MIN_SHIFT = 5;
  localparam int MAX_SHIFT = 25;
  localparam int ACC_BITS = 48;
  function automatic logic shift_ok(input logic [SHIFT_W-1:0] s);
    return (s >= SHIFT_W'(MIN_SHIFT)) && (s <= SHIFT_W'(MAX_SHIFT));
  endfunction
endpackage

// File: rtl/bias_lshift_sat_if.sv
// bias_lshift_sat_if: valid/ready operand stream in, shifted result stream out
interface bias_lshift_sat_if #(parameter int IN_BITS = 16, parameter int OUT_BITS = 48);
  logic                s_valid;
  logic                s_ready;
  logic [IN_BITS-1:0]  s_data;
  logic                m_valid;
  logic                m_ready;
  logic [OUT_BITS-1:0] m_data;
  logic                m_sat;
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_sat);
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_sat);
endinterface

// File: rtl/bias_lshift_sat_clamp.sv
// bias_lshift_sat_clamp: combinational signed clamp of a wide word to OUT_W bits with flag
module bias_lshift_sat_clamp #(
  parameter int IN_W = 41,
  parameter int OUT_W = 48
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);
  if (IN_W > OUT_W) begin : g_clamp
    logic ovf;
    always_comb begin
      ovf = din[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){din[IN_W-1]}};
      sat = ovf;
      dout = ovf ? {din[IN_W-1], {(OUT_W-1){~din[IN_W-1]}}} : din[OUT_W-1:0];
    end
  end else begin : g_pass
    assign dout = OUT_W'($signed(din));
    assign sat = 1'b0;
  end
endmodule

// File: rtl/bias_lshift_sat.sv
// bias_lshift_sat: two-stage saturating arithmetic left shifter on a valid/ready stream
module bias_lshift_sat
  import bias_lshift_sat_pkg::*;
#(
  parameter int IN_BITS = 16,
  parameter int OUT_BITS = ACC_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               cfg_err,
  input  logic               sat_clr,
  output logic [15:0]        sat_cnt,
  bias_lshift_sat_if.slave   bus
);
  localparam int W = IN_BITS + MAX_SHIFT;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic                cfg_err_q, cfg_err_d;
  logic                v1_q, v1_d;
  logic [W-1:0]        w1_q, w1_d;
  logic                m_valid_q, m_valid_d;
  logic [OUT_BITS-1:0] m_data_q, m_data_d;
  logic                m_sat_q, m_sat_d;
  logic [15:0]         sat_cnt_q, sat_cnt_d;
  logic [OUT_BITS-1:0] cl_data;
  logic                cl_sat;
  logic                adv, take, cnt_inc;
  bias_lshift_sat_clamp #(.IN_W(W), .OUT_W(OUT_BITS)) u_clamp (
    .din  (w1_q),
    .dout (cl_data),
    .sat  (cl_sat)
  );
  always_comb begin
    adv = ~m_valid_q | bus.m_ready;
    take = adv & bus.s_valid;
    cnt_inc = m_valid_q & bus.m_ready & m_sat_q & ~&sat_cnt_q;
    shift_d = cfg_we ? cfg_shift : shift_q;
    cfg_err_d = (cfg_err_q & ~sat_clr) | (cfg_we & ~shift_ok(cfg_shift));
    v1_d = adv ? bus.s_valid : v1_q;
    // an illegal shift zeroes the beat at capture so it can never clamp downstream
    w1_d = take ? (shift_ok(shift_q) ? (W'($signed(bus.s_data)) << shift_q) : '0) : w1_q;
    m_valid_d = adv ? v1_q : m_valid_q;
    m_data_d = (adv & v1_q) ? cl_data : m_data_q;
    m_sat_d = (adv & v1_q) ? cl_sat : m_sat_q;
    sat_cnt_d = sat_clr ? '0 : cnt_inc ? sat_cnt_q + 16'd1 : sat_cnt_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      shift_q <= SHIFT_W'(MIN_SHIFT);
      cfg_err_q <= 1'b0;
      v1_q <= 1'b0;
      w1_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_sat_q <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      shift_q <= shift_d;
      cfg_err_q <= cfg_err_d;
      v1_q <= v1_d;
      w1_q <= w1_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_sat_q <= m_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  assign bus.s_ready = adv;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data = m_data_q;
  assign bus.m_sat = m_sat_q;
  assign cfg_err = cfg_err_q;
  assign sat_cnt = sat_cnt_q;
endmodule

// File: tb/tb_bias_lshift_sat.sv
// tb_bias_lshift_sat: randomized and directed checks against an arithmetic reference model
module tb_bias_lshift_sat;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [4:0] cfg_shift = 5'd0;
  logic cfg_err;
  logic sat_clr = 1'b0;
  logic [15:0] sat_cnt;
  int errors = 0;
  int checks = 0;
  int n_out = 0;
  bit armed = 1'b0;
  logic [32:0] exp_q[$];
  int m_shift = 5;
  logic [15:0] m_cnt = 16'd0;
  bit m_err = 1'b0;

  bias_lshift_sat_if #(.IN_BITS(16), .OUT_BITS(32)) bus ();

  bias_lshift_sat #(.IN_BITS(16), .OUT_BITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_shift (cfg_shift),
    .cfg_err   (cfg_err),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [15:0] d, input int sh);
    longint v;
    if (sh < 5 || sh > 25) return 33'd0;
    v = longint'($signed(d)) * (longint'(1) << sh);
    if (v > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
    if (v < -64'sd2147483648) return {1'b1, 32'h80000000};
    return {1'b0, v[31:0]};
  endfunction

  // Scoreboard: handshakes seen at the negedge are the ones the next rising edge commits
  always @(negedge clk) begin
    logic [32:0] e;
    logic inc;
    inc = 1'b0;
    if (armed && !rst) begin
      checks++;
      if (sat_cnt !== m_cnt) begin errors++; $display("FAIL sat_cnt got=%h want=%h", sat_cnt, m_cnt); end
      checks++;
      if (cfg_err !== m_err) begin errors++; $display("FAIL cfg_err got=%b want=%b", cfg_err, m_err); end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_out got=%h want=none", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          inc = e[32];
          if ({bus.m_sat, bus.m_data} !== e) begin
            errors++; $display("FAIL out_beat got=%b/%h want=%b/%h", bus.m_sat, bus.m_data, e[32], e[31:0]);
          end
        end
      end
      m_cnt = sat_clr ? 16'd0 : (inc && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
      m_err = (m_err && !sat_clr) || (cfg_we && (cfg_shift < 5 || cfg_shift > 25));
      if (bus.s_valid && bus.s_ready) exp_q.push_back(model(bus.s_data, m_shift));
      if (cfg_we) m_shift = int'(cfg_shift);
    end
    if (rst) begin armed = 1'b1; exp_q.delete(); m_shift = 5; m_cnt = 16'd0; m_err = 1'b0; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [4:0] s);
    tick(); cfg_we = 1'b1; cfg_shift = s;
    tick(); cfg_we = 1'b0;
  endtask

  task automatic drain();
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.m_valid); i++) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain pending=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    tick(); tick(); rst = 1'b0;
    checks++;
    if ({bus.m_valid, bus.m_sat, bus.m_data, sat_cnt, cfg_err, bus.s_ready} !== {1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_state got v=%b s=%b d=%h c=%h e=%b r=%b want 0/0/0/0/0/1",
        bus.m_valid, bus.m_sat, bus.m_data, sat_cnt, cfg_err, bus.s_ready);
    end
  endtask

  task automatic test_latency();
    cfg(5'd8);
    bus.s_valid = 1'b1; bus.s_data = 16'h0003; bus.m_ready = 1'b1;
    tick(); bus.s_valid = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b want=0", bus.m_valid); end
    tick();
    checks++;
    if ({bus.m_valid, bus.m_sat, bus.m_data} !== {1'b1, 1'b0, 32'h300}) begin
      errors++; $display("FAIL latency_out got=%b/%b/%h want=1/0/00000300", bus.m_valid, bus.m_sat, bus.m_data);
    end
    drain();
  endtask

  task automatic test_sat();
    cfg(5'd20);
    bus.s_valid = 1'b1; bus.s_data = 16'h7FFF;
    tick(); bus.s_data = 16'h8000;
    tick(); bus.s_valid = 1'b0;
    checks++;
    if ({bus.m_sat, bus.m_data} !== {1'b1, 32'h7FFFFFFF}) begin
      errors++; $display("FAIL sat_pos got=%b/%h want=1/7fffffff", bus.m_sat, bus.m_data);
    end
    tick();
    checks++;
    if ({sat_cnt, bus.m_sat, bus.m_data} !== {16'd1, 1'b1, 32'h80000000}) begin
      errors++; $display("FAIL sat_neg got=%0d/%b/%h want=1/1/80000000", sat_cnt, bus.m_sat, bus.m_data);
    end
    tick();
    checks++;
    if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt2 got=%0d want=2", sat_cnt); end
    drain();
  endtask

  task automatic test_stream();
    int idx, n0;
    bit held_v;
    logic [31:0] held;
    idx = 0; n0 = n_out; held_v = 1'b0; held = '0;
    cfg(5'd5);
    for (int c = 0; c < 60; c++) begin
      if (idx == 8 && exp_q.size() == 0 && !bus.m_valid) break;
      if (held_v) begin
        checks++;
        if (!bus.m_valid || bus.m_data !== held) begin
          errors++; $display("FAIL stall_hold got=%b/%h want=1/%h", bus.m_valid, bus.m_data, held);
        end
      end
      bus.m_ready = (c % 2 == 0);
      bus.s_valid = (idx < 8);
      bus.s_data = 16'(idx + 1);
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) idx++;
      held_v = bus.m_valid && !bus.m_ready;
      held = bus.m_data;
      tick();
    end
    checks++;
    if (n_out - n0 != 8 || idx != 8) begin errors++; $display("FAIL stream_count got=%0d/%0d want=8/8", n_out - n0, idx); end
    drain();
  endtask

  task automatic test_cfg_same_cycle();
    cfg(5'd5);
    cfg_we = 1'b1; cfg_shift = 5'd10; bus.s_valid = 1'b1; bus.s_data = 16'd1; bus.m_ready = 1'b1;
    tick(); cfg_we = 1'b0;
    tick(); bus.s_valid = 1'b0;
    checks++;
    if (bus.m_data !== 32'd32) begin errors++; $display("FAIL cfg_old_shift got=%0d want=32", bus.m_data); end
    tick();
    checks++;
    if ({bus.m_valid, bus.m_data} !== {1'b1, 32'd1024}) begin
      errors++; $display("FAIL cfg_new_shift got=%b/%0d want=1/1024", bus.m_valid, bus.m_data);
    end
    drain();
  endtask

  task automatic test_illegal();
    cfg(5'd3);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set got=%b want=1", cfg_err); end
    bus.s_valid = 1'b1; bus.s_data = 16'h0011;
    tick(); bus.s_valid = 1'b0;
    tick();
    checks++;
    if ({bus.m_valid, bus.m_sat, bus.m_data} !== {1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL illegal_out got=%b/%b/%h want=1/0/0", bus.m_valid, bus.m_sat, bus.m_data);
    end
    tick(); sat_clr = 1'b1;
    tick(); sat_clr = 1'b0;
    checks++;
    if ({cfg_err, sat_cnt} !== {1'b0, 16'd0}) begin
      errors++; $display("FAIL sat_clr got=%b/%0d want=0/0", cfg_err, sat_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    bus.m_ready = 1'b0; bus.s_valid = 1'b1; bus.s_data = 16'd1;
    tick(); bus.s_data = 16'd2;
    tick(); bus.s_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; bus.m_ready = 1'b1;
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b want=0", bus.m_valid); end
    tick(); tick();
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_ghost got=%b want=0", bus.m_valid); end
    bus.s_valid = 1'b1; bus.s_data = 16'd1;
    tick(); bus.s_valid = 1'b0;
    tick();
    checks++;
    if ({bus.m_valid, bus.m_data} !== {1'b1, 32'd32}) begin
      errors++; $display("FAIL rst_shift got=%b/%0d want=1/32", bus.m_valid, bus.m_data);
    end
    drain();
  endtask

  task automatic test_clr_same_cycle();
    cfg(5'd20);
    bus.s_valid = 1'b1; bus.s_data = 16'h7FFF;
    tick(); bus.s_valid = 1'b0;
    tick(); sat_clr = 1'b1;
    tick(); sat_clr = 1'b0;
    checks++;
    if (sat_cnt !== 16'd0) begin errors++; $display("FAIL clr_vs_count got=%0d want=0", sat_cnt); end
    drain();
  endtask

  task automatic test_random();
    logic [15:0] pool [4];
    pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h7FFF; pool[3] = 16'h8000;
    for (int c = 0; c < 400; c++) begin
      cfg_we = ($urandom_range(0, 15) == 0);
      cfg_shift = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(5, 25)) : 5'($urandom_range(0, 31));
      sat_clr = ($urandom_range(0, 31) == 0);
      bus.s_valid = $urandom_range(0, 1) == 1;
      bus.s_data = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
      bus.m_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    cfg_we = 1'b0; sat_clr = 1'b0;
    drain();
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    test_reset();
    test_latency();
    test_sat();
    test_stream();
    test_cfg_same_cycle();
    test_illegal();
    test_reset_midstream();
    test_clr_same_cycle();
    test_random();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
